lsu_align: RTL and testbench

Load/store alignment unit in the memory stage, between the execute-stage address/data outputs and the word-organised data RAM. It turns byte, half and word requests at any byte address into one or two word-wide RAM accesses with byte enables. For loads it right-justifies the addressed bytes into bit 0 and hands the unextended result to the downstream zero/sign-extension stage. Misaligned accesses that cross a word boundary are split into two sequential RAM accesses by a small state machine.

---
 rtl/lsu_align.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_align.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align.sv
// lsu_align: memory-stage load/store alignment unit. Turns byte/half/word requests
// into one or two word-wide RAM accesses and right-justifies the loaded bytes.
module lsu_align #(
   parameter int CPU_WORD = 32,
   parameter int BYTE_LEN = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic [CPU_WORD-1:0] req_addr,
   input  logic [CPU_WORD-1:0] req_wdata,
   output logic                resp_valid,
   output logic [CPU_WORD-1:0] resp_rdata,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [CPU_WORD-3:0] mem_addr,
   output logic [3:0]          mem_be,
   output logic [CPU_WORD-1:0] mem_wdata,
   input  logic                mem_rvalid,
   input  logic [CPU_WORD-1:0] mem_rdata,
   output logic [2:0]          dbg_state
);

   localparam int NB = CPU_WORD / BYTE_LEN;
   localparam int WA = CPU_WORD - 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      DONE  = 3'd5
   } state_e;

   state_e                state_q;
   logic                  we_q;
   logic [1:0]            size_q;
   logic [CPU_WORD-1:0]   addr_q;
   logic [CPU_WORD-1:0]   wdata_q;
   logic [CPU_WORD-1:0]   rd0_q;

   function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
      logic [NB-1:0] m;
      m = '0;
      case (size)
         2'b00:   m[0]   = 1'b1;
         2'b01:   m[1:0] = 2'b11;
         default: m      = '1;
      endcase
      return m;
   endfunction

   // hi selects the upper word of the shifted 2-word window (second access).
   function automatic logic [NB-1:0] lane_be(input logic [1:0] size, input logic [1:0] off,
                                             input logic hi);
      logic [2*NB-1:0] w;
      w = {{NB{1'b0}}, size_mask(size)} << off;
      return hi ? w[2*NB-1:NB] : w[NB-1:0];
   endfunction

   function automatic logic [CPU_WORD-1:0] lane_data(input logic [CPU_WORD-1:0] data,
                                                     input logic [1:0] off, input logic hi);
      logic [2*CPU_WORD-1:0] w;
      w = {{CPU_WORD{1'b0}}, data} << (int'(off) * BYTE_LEN);
      return hi ? w[2*CPU_WORD-1:CPU_WORD] : w[CPU_WORD-1:0];
   endfunction

   function automatic logic [CPU_WORD-1:0] extract(input logic [2*CPU_WORD-1:0] both,
                                                   input logic [1:0] off, input logic [1:0] size);
      logic [2*CPU_WORD-1:0] sh;
      logic [NB-1:0]         m;
      logic [CPU_WORD-1:0]   r;
      sh = both >> (int'(off) * BYTE_LEN);
      m  = size_mask(size);
      r  = '0;
      for (int i = 0; i < NB; i++) begin
         r[i*BYTE_LEN +: BYTE_LEN] = m[i] ? sh[i*BYTE_LEN +: BYTE_LEN] : '0;
      end
      return r;
   endfunction

   logic [NB-1:0]       req_be0;
   logic [CPU_WORD-1:0] req_wdata0;
   logic [NB-1:0]       cap_be1;
   logic [CPU_WORD-1:0] cap_wdata1;
   logic [WA-1:0]       cap_addr1;
   logic                split;

   assign req_be0    = lane_be(req_size, req_addr[1:0], 1'b0);
   assign req_wdata0 = lane_data(req_wdata, req_addr[1:0], 1'b0);
   assign cap_be1    = lane_be(size_q, addr_q[1:0], 1'b1);
   assign cap_wdata1 = lane_data(wdata_q, addr_q[1:0], 1'b1);
   assign cap_addr1  = addr_q[CPU_WORD-1:2] + WA'(1);
   // Any byte spilling into the upper window word means a second access.
   assign split      = |cap_be1;

   assign req_ready = (state_q == IDLE);
   assign dbg_state = state_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd0_q      <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  size_q    <= req_size;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  mem_req   <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= req_addr[CPU_WORD-1:2];
                  mem_be    <= req_be0;
                  mem_wdata <= req_wdata0;
                  state_q   <= REQ0;
               end
            end
            REQ0: begin
               if (mem_gnt) begin
                  if (!we_q) begin
                     mem_req <= 1'b0;
                     state_q <= WAIT0;
                  end else if (split) begin
                     mem_addr  <= cap_addr1;
                     mem_be    <= cap_be1;
                     mem_wdata <= cap_wdata1;
                     state_q   <= REQ1;
                  end else begin
                     mem_req    <= 1'b0;
                     resp_valid <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            WAIT0: begin
               if (mem_rvalid) begin
                  rd0_q <= mem_rdata;
                  if (split) begin
                     mem_req   <= 1'b1;
                     mem_we    <= we_q;
                     mem_addr  <= cap_addr1;
                     mem_be    <= cap_be1;
                     mem_wdata <= cap_wdata1;
                     state_q   <= REQ1;
                  end else begin
                     resp_rdata <= extract({{CPU_WORD{1'b0}}, mem_rdata}, addr_q[1:0], size_q);
                     resp_valid <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            REQ1: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  if (!we_q) begin
                     state_q <= WAIT1;
                  end else begin
                     resp_valid <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            WAIT1: begin
               if (mem_rvalid) begin
                  resp_rdata <= extract({mem_rdata, rd0_q}, addr_q[1:0], size_q);
                  resp_valid <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               mem_req <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: byte-addressed reference memory and transaction model driving
// lsu_align with directed cases and randomized loads/stores with random stalls.
module tb_lsu_align;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_gnt, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   lsu_align dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   typedef struct packed {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } acc_t;

   logic [7:0]  ram [logic [31:0]];
   acc_t        acc_q[$];
   acc_t        glog[$];
   logic [31:0] exp_q[$];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit active, pending, resp_due, chk_en, done_flag, acc_flag, junk_en, force_rv;
   int rv_cnt, stall_cnt, acc_cyc, last_lat;
   int gnt_stall_fixed = 0;
   int rv_delay_fixed  = 1;
   logic [29:0] pend_addr;
   logic [31:0] last_rdata;
   logic        p_req, p_we;
   logic [29:0] p_addr;
   logic [3:0]  p_be;
   logic [31:0] p_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_assert++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   function automatic logic [31:0] ram_word(input logic [29:0] w);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = ram_byte({w, 2'b00} + 32'(i));
      return r;
   endfunction

   task automatic set_word(input logic [29:0] w, input logic [31:0] d);
      for (int i = 0; i < 4; i++) ram[{w, 2'b00} + 32'(i)] = d[i*8 +: 8];
   endtask

   function automatic logic [31:0] lanes(input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{be[i]}};
      return r;
   endfunction

   // Walk the request byte by byte; every new word address starts a new RAM access.
   task automatic plan_txn(input logic we, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd);
      int          n;
      int          lane;
      bit          have;
      acc_t        cur;
      logic [31:0] ba;
      logic [31:0] res;
      n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      res  = '0;
      have = 0;
      cur  = '0;
      acc_q.delete();
      for (int k = 0; k < n; k++) begin
         ba = a + 32'(k);
         if (have && cur.addr != ba[31:2]) begin
            acc_q.push_back(cur);
            have = 0;
         end
         if (!have) begin
            cur  = '{we, ba[31:2], 4'b0000, 32'h0};
            have = 1;
         end
         lane = int'(ba[1:0]);
         cur.be[lane] = 1'b1;
         if (we) cur.wdata[lane*8 +: 8] = wd[k*8 +: 8];
         res[k*8 +: 8] = ram_byte(ba);
      end
      acc_q.push_back(cur);
      if (!we) exp_q.push_back(res);
   endtask

   // One clock: account for what the last edge did, check this cycle's outputs,
   // then drive the RAM side for the coming edge.
   task automatic tick();
      bit   acc_now;
      bit   exp_req_prev;
      acc_t e;
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         active = 0; pending = 0; resp_due = 0; stall_cnt = 0;
         acc_q.delete(); exp_q.delete();
         last_rdata = '0;
         chk_en = 1;
      end else if (chk_en) begin
         exp_req_prev = active && acc_q.size() > 0 && !pending;
         acc_now      = req_valid && !active;
         if (p_req && !mem_gnt) begin
            check("hold_we",    32'(mem_we),    32'(p_we));
            check("hold_addr",  32'(mem_addr),  32'(p_addr));
            check("hold_be",    32'(mem_be),    32'(p_be));
            check("hold_wdata", mem_wdata,      p_wdata);
         end
         if (resp_due) begin
            active   = 0;
            resp_due = 0;
         end
         if (pending && mem_rvalid) begin
            pending = 0;
            if (acc_q.size() == 0 && exp_q.size() > 0) begin
               resp_due   = 1;
               last_rdata = exp_q.pop_front();
            end
         end
         if (exp_req_prev && mem_gnt) begin
            e = acc_q.pop_front();
            glog.push_back('{p_we, p_addr, p_be, p_wdata});
            check("acc_we",   32'(p_we),   32'(e.we));
            check("acc_addr", 32'(p_addr), 32'(e.addr));
            check("acc_be",   32'(p_be),   32'(e.be));
            stall_cnt = 0;
            if (e.we) begin
               check("acc_wdata", p_wdata & lanes(e.be), e.wdata);
               for (int i = 0; i < 4; i++)
                  if (e.be[i]) ram[{e.addr, 2'b00} + 32'(i)] = e.wdata[i*8 +: 8];
               if (acc_q.size() == 0) resp_due = 1;
            end else begin
               pending   = 1;
               pend_addr = e.addr;
               rv_cnt    = (rv_delay_fixed < 0) ? int'($urandom_range(1, 3)) : rv_delay_fixed;
            end
         end
         if (acc_now) begin
            plan_txn(req_we, req_size, req_addr, req_wdata);
            active   = 1;
            acc_flag = 1;
            acc_cyc  = cyc - 1;
         end
      end
      if (chk_en) begin
         check("req_ready",  32'(req_ready),  32'(!active));
         check("mem_req",    32'(mem_req),    32'(active && acc_q.size() > 0 && !pending));
         check("resp_valid", 32'(resp_valid), 32'(resp_due));
         check("resp_rdata", resp_rdata,      last_rdata);
         if (resp_due) begin
            done_flag = 1;
            last_lat  = cyc - acc_cyc;
         end
      end
      p_req = mem_req; p_we = mem_we; p_addr = mem_addr; p_be = mem_be; p_wdata = mem_wdata;
      if (mem_req) begin
         if (gnt_stall_fixed < 0) begin
            mem_gnt = ($urandom_range(0, 2) != 0);
         end else if (stall_cnt < gnt_stall_fixed) begin
            mem_gnt = 1'b0;
            stall_cnt++;
         end else begin
            mem_gnt = 1'b1;
         end
      end else begin
         mem_gnt = 1'($urandom_range(0, 1));
      end
      if (force_rv) begin
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         force_rv   = 0;
      end else if (pending) begin
         if (rv_cnt <= 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = ram_word(pend_addr);
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            rv_cnt--;
         end
      end else begin
         mem_rvalid = junk_en && ($urandom_range(0, 9) == 0);
         mem_rdata  = $urandom;
      end
   endtask

   task automatic run_txn(input logic we, input logic [1:0] size, input logic [31:0] a,
                          input logic [31:0] wd);
      int t;
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = a; req_wdata = wd;
      acc_flag  = 0;
      done_flag = 0;
      t = 0;
      while (!acc_flag && t < 100) begin
         tick();
         t++;
      end
      check("accept_timeout", 32'(acc_flag), 32'd1);
      req_valid = 1'b0;
      req_we    = 1'($urandom_range(0, 1));
      req_size  = 2'($urandom_range(0, 3));
      req_addr  = $urandom;
      req_wdata = $urandom;
      t = 0;
      while (acc_flag && !done_flag && t < 200) begin
         tick();
         t++;
      end
      check("resp_timeout", 32'(done_flag), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [31:0] a;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_be = '0; p_wdata = '0;
      last_rdata = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // sw 0xDEADBEEF @0x100
      glog.delete();
      run_txn(1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF);
      check("sw_count", 32'(glog.size()), 32'd1);
      if (glog.size() >= 1) begin
         check("sw_addr",  32'(glog[0].addr), 32'h40);
         check("sw_be",    32'(glog[0].be),   32'hF);
         check("sw_wdata", glog[0].wdata,     32'hDEAD_BEEF);
         check("sw_we",    32'(glog[0].we),   32'd1);
      end
      check("sw_lat", 32'(last_lat), 32'd2);

      // lb @0x101
      set_word(30'h40, 32'h4433_2211);
      glog.delete();
      run_txn(1'b0, 2'b00, 32'h0000_0101, 32'h0);
      if (glog.size() >= 1) begin
         check("lb_addr", 32'(glog[0].addr), 32'h40);
         check("lb_be",   32'(glog[0].be),   32'h2);
      end
      check("lb_rdata", resp_rdata, 32'h0000_0022);
      check("lb_lat",   32'(last_lat), 32'd3);

      // split sh 0xABCD @0x103
      glog.delete();
      run_txn(1'b1, 2'b01, 32'h0000_0103, 32'h0000_ABCD);
      check("sh_count", 32'(glog.size()), 32'd2);
      if (glog.size() >= 2) begin
         check("sh_addr0",  32'(glog[0].addr), 32'h40);
         check("sh_be0",    32'(glog[0].be),   32'h8);
         check("sh_wdata0", glog[0].wdata,     32'hCD00_0000);
         check("sh_addr1",  32'(glog[1].addr), 32'h41);
         check("sh_be1",    32'(glog[1].be),   32'h1);
         check("sh_wdata1", glog[1].wdata,     32'h0000_00AB);
      end
      check("sh_lat", 32'(last_lat), 32'd3);

      // aligned lw and split lw latency with immediate responses
      set_word(30'h40, 32'h4433_2211);
      set_word(30'h41, 32'h8877_6655);
      run_txn(1'b0, 2'b10, 32'h0000_0100, 32'h0);
      check("lw_rdata", resp_rdata, 32'h4433_2211);
      check("lw_lat",   32'(last_lat), 32'd3);
      run_txn(1'b0, 2'b10, 32'h0000_0102, 32'h0);
      check("lw_split_lat", 32'(last_lat), 32'd5);

      // split lw with grant stalls and slow read data
      gnt_stall_fixed = 2;
      rv_delay_fixed  = 3;
      glog.delete();
      run_txn(1'b0, 2'b10, 32'h0000_0102, 32'h0);
      check("lw_stall_rdata", resp_rdata, 32'h6655_4433);
      if (glog.size() >= 2) begin
         check("lw_stall_be0", 32'(glog[0].be), 32'hC);
         check("lw_stall_be1", 32'(glog[1].be), 32'h3);
      end
      gnt_stall_fixed = 0;
      rv_delay_fixed  = 1;

      // address wrap at the top of memory
      glog.delete();
      run_txn(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);
      check("wrap_count", 32'(glog.size()), 32'd2);
      if (glog.size() >= 2) begin
         check("wrap_addr0", 32'(glog[0].addr), 32'h3FFF_FFFF);
         check("wrap_be0",   32'(glog[0].be),   32'hC);
         check("wrap_addr1", 32'(glog[1].addr), 32'h0);
         check("wrap_be1",   32'(glog[1].be),   32'h3);
      end

      // reset while waiting for read data, then a late rvalid
      rv_delay_fixed = 6;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h104; req_wdata = '0;
      acc_flag = 0;
      t = 0;
      while (!acc_flag && t < 20) begin
         tick();
         t++;
      end
      req_valid = 1'b0;
      t = 0;
      while (!pending && t < 20) begin
         tick();
         t++;
      end
      check("rst_reached_wait", 32'(pending), 32'd1);
      rst_n    = 1'b0;
      force_rv = 1;
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_ready", 32'(req_ready), 32'd1);
      rv_delay_fixed = 1;
      set_word(30'h40, 32'h4433_2211);
      run_txn(1'b0, 2'b10, 32'h0000_0100, 32'h0);
      check("post_rst_rdata", resp_rdata, 32'h4433_2211);
      check("post_rst_lat",   32'(last_lat), 32'd3);

      // randomized loads/stores with random stalls and stray grant/rvalid
      junk_en         = 1;
      gnt_stall_fixed = -1;
      rv_delay_fixed  = -1;
      for (int i = 0; i < 300; i++) begin
         a = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_0200)
             + 32'($urandom_range(0, 15));
         run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
         repeat ($urandom_range(0, 2)) tick();
      end
      junk_en = 0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
